// File: rtl/alu_src_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle ALU source controller.
// ALU_SRC_CTRL_SHIFT_EN enables the variable-shift R-type functions.
package alu_src_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_e;

    typedef enum logic [2:0] {
        C_RTYPE,
        C_SHIFT,
        C_ADDI,
        C_LOAD,
        C_STORE,
        C_BEQ,
        C_BNE,
        C_NONE
    } iclass_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;

    localparam logic [1:0] SRCA_PC  = 2'b00;
    localparam logic [1:0] SRCA_A   = 2'b01;
    localparam logic [1:0] SRCA_B   = 2'b10;

    localparam logic [2:0] SRCB_B     = 3'b000;
    localparam logic [2:0] SRCB_4     = 3'b001;
    localparam logic [2:0] SRCB_IMM   = 3'b010;
    localparam logic [2:0] SRCB_IMMSH = 3'b011;
    localparam logic [2:0] SRCB_A     = 3'b100;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SLL  = 3'b101;
    localparam logic [2:0] ALU_SRL  = 3'b110;
    localparam logic [2:0] ALU_SRA  = 3'b111;

    function automatic logic br_taken(input iclass_e c, input logic z);
        return ((c == C_BEQ) && z) || ((c == C_BNE) && !z);
    endfunction

endpackage

// File: rtl/alu_src_ctrl_if.sv
// Bundle of instruction, memory handshake and datapath control signals.
// Master drives instruction/handshake, slave drives the control outputs.
interface alu_src_ctrl_if;

    logic       mem_ready;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic [1:0] alu_src_a_sel;
    logic [2:0] alu_src_b_sel;
    logic [2:0] alu_op;
    logic       ir_write;
    logic       pc_write;
    logic       alu_out_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       pc_src;
    logic       illegal;

    modport master (
        output mem_ready, opcode, funct, zero,
        input  alu_src_a_sel, alu_src_b_sel, alu_op,
        input  ir_write, pc_write, alu_out_write, reg_write,
        input  mem_read, mem_write, pc_src, illegal
    );

    modport slave (
        input  mem_ready, opcode, funct, zero,
        output alu_src_a_sel, alu_src_b_sel, alu_op,
        output ir_write, pc_write, alu_out_write, reg_write,
        output mem_read, mem_write, pc_src, illegal
    );

endinterface

// File: rtl/alu_src_ctrl_decode.sv
// Combinational opcode/funct classifier producing class, ALU op and legality.
// Shift functs decode only when ALU_SRC_CTRL_SHIFT_EN is defined.
import alu_src_ctrl_pkg::*;

module alu_src_ctrl_decode (
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output iclass_e    o_class,
    output logic [2:0] o_alu_op,
    output logic       o_legal
);

    always_comb begin
        o_class  = C_NONE;
        o_alu_op = ALU_ADD;
        unique case (1'b1)
            (i_opcode == OP_RTYPE): begin
                unique case (1'b1)
                    (i_funct == FN_ADD): begin
                        o_class  = C_RTYPE;
                        o_alu_op = ALU_ADD;
                    end
                    (i_funct == FN_SUB): begin
                        o_class  = C_RTYPE;
                        o_alu_op = ALU_SUB;
                    end
                    (i_funct == FN_AND): begin
                        o_class  = C_RTYPE;
                        o_alu_op = ALU_AND;
                    end
                    (i_funct == FN_OR): begin
                        o_class  = C_RTYPE;
                        o_alu_op = ALU_OR;
                    end
                    (i_funct == FN_XOR): begin
                        o_class  = C_RTYPE;
                        o_alu_op = ALU_XOR;
                    end
`ifdef ALU_SRC_CTRL_SHIFT_EN
                    (i_funct == FN_SLLV): begin
                        o_class  = C_SHIFT;
                        o_alu_op = ALU_SLL;
                    end
                    (i_funct == FN_SRLV): begin
                        o_class  = C_SHIFT;
                        o_alu_op = ALU_SRL;
                    end
                    (i_funct == FN_SRAV): begin
                        o_class  = C_SHIFT;
                        o_alu_op = ALU_SRA;
                    end
`endif
                    default: ;
                endcase
            end
            (i_opcode == OP_ADDI): o_class = C_ADDI;
            (i_opcode == OP_LW):   o_class = C_LOAD;
            (i_opcode == OP_SW):   o_class = C_STORE;
            (i_opcode == OP_BEQ): begin
                o_class  = C_BEQ;
                o_alu_op = ALU_SUB;
            end
            (i_opcode == OP_BNE): begin
                o_class  = C_BNE;
                o_alu_op = ALU_SUB;
            end
            default: ;
        endcase
    end

    assign o_legal = (o_class != C_NONE);

endmodule

// File: rtl/alu_src_ctrl.sv
// Multi-cycle control FSM selecting ALU operands/op and datapath strobes.
// ALU_SRC_CTRL_SHIFT_EN adds sllv/srlv/srav execution (B value, A amount).
import alu_src_ctrl_pkg::*;

module alu_src_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mem_ready,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [1:0] alu_src_a_sel,
    output logic [2:0] alu_src_b_sel,
    output logic [2:0] alu_op,
    output logic       ir_write,
    output logic       pc_write,
    output logic       alu_out_write,
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       pc_src,
    output logic       illegal
);

    state_e     r_state;
    state_e     w_next;
    logic [5:0] r_opcode;
    logic [5:0] r_funct;
    logic       r_illegal;

    iclass_e    w_class;
    logic [2:0] w_dec_op;
    logic       w_legal;
    logic       w_taken;

    logic       w_ir_write;
    logic       w_pc_write;
    logic       w_alu_out_write;
    logic       w_reg_write;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_pc_src;

    alu_src_ctrl_decode u_dec (
        .i_opcode (r_opcode),
        .i_funct  (r_funct),
        .o_class  (w_class),
        .o_alu_op (w_dec_op),
        .o_legal  (w_legal)
    );

    assign w_taken = br_taken(w_class, zero);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_opcode  <= 6'h00;
            r_funct   <= 6'h00;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_ir_write) begin
                r_opcode <= opcode;
                r_funct  <= funct;
            end
            if ((r_state == S_DECODE) && !w_legal) begin
                r_illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next          = r_state;
        alu_src_a_sel   = SRCA_PC;
        alu_src_b_sel   = SRCB_4;
        alu_op          = ALU_ADD;
        w_ir_write      = 1'b0;
        w_pc_write      = 1'b0;
        w_alu_out_write = 1'b0;
        w_reg_write     = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_pc_src        = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                w_mem_read = 1'b1;
                if (mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b_sel   = SRCB_IMMSH;
                w_alu_out_write = 1'b1;
                w_next          = w_legal ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                unique case (w_class)
                    C_RTYPE: begin
                        alu_src_a_sel   = SRCA_A;
                        alu_src_b_sel   = SRCB_B;
                        alu_op          = w_dec_op;
                        w_alu_out_write = 1'b1;
                        w_next          = S_WB;
                    end
`ifdef ALU_SRC_CTRL_SHIFT_EN
                    C_SHIFT: begin
                        alu_src_a_sel   = SRCA_B;
                        alu_src_b_sel   = SRCB_A;
                        alu_op          = w_dec_op;
                        w_alu_out_write = 1'b1;
                        w_next          = S_WB;
                    end
`endif
                    C_ADDI, C_LOAD, C_STORE: begin
                        alu_src_a_sel   = SRCA_A;
                        alu_src_b_sel   = SRCB_IMM;
                        w_alu_out_write = 1'b1;
                        w_next = (w_class == C_ADDI) ? S_WB : S_MEM;
                    end
                    C_BEQ, C_BNE: begin
                        alu_src_a_sel = SRCA_A;
                        alu_src_b_sel = SRCB_B;
                        alu_op        = ALU_SUB;
                        w_pc_write    = w_taken;
                        w_pc_src      = w_taken;
                        w_next        = S_FETCH;
                    end
                    default: w_next = S_TRAP;
                endcase
            end
            S_MEM: begin
                w_mem_read  = (w_class == C_LOAD);
                w_mem_write = (w_class != C_LOAD);
                if (mem_ready) begin
                    w_next = (w_class == C_LOAD) ? S_WB : S_FETCH;
                end
            end
            S_WB: begin
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_TRAP: w_next = S_TRAP;
            default: w_next = S_FETCH;
        endcase
    end

    // Gate strobes so they are silent while reset is held, not just after it.
    assign ir_write      = w_ir_write      & rst_n;
    assign pc_write      = w_pc_write      & rst_n;
    assign alu_out_write = w_alu_out_write & rst_n;
    assign reg_write     = w_reg_write     & rst_n;
    assign mem_read      = w_mem_read      & rst_n;
    assign mem_write     = w_mem_write     & rst_n;
    assign pc_src        = w_pc_src        & rst_n;
    assign illegal       = r_illegal;

endmodule
